clken_synth: RTL
================

CLKEN_SYNTH -- requirements
Module: clken_synth

Interface
REQ-001 The block SHALL have parameter NCH, default 2, meaning the number of independent clock-enable channels (1..8).
REQ-002 The block SHALL have parameter ACC_W, default 24, meaning the phase-accumulator width in bits (8..32).
REQ-003 The block SHALL have parameter SETTLE, default 16, meaning the number of enable pulses required before lock asserts (1..255).
REQ-004 The block SHALL have port clkin, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: a configuration request is present.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration request.
REQ-008 The block SHALL have port cfg_ch, input, 3 bits: target channel index.
REQ-009 The block SHALL have port cfg_inc, input, ACC_W bits: phase increment; output frequency = f_clkin*cfg_inc/2^ACC_W.
REQ-010 The block SHALL have port cfg_en, input, 1 bit: enables the target channel.
REQ-011 The block SHALL have port clken, output, NCH bits: one-cycle enable pulse per channel.
REQ-012 The block SHALL have port clkout, output, NCH bits: square wave per channel, equal to the accumulator MSB.
REQ-013 The block SHALL have port lock, output, NCH bits: the channel is settled and running.

Function
REQ-014 A request SHALL be accepted on a rising edge where cfg_valid=1 and cfg_ready=1; back-to-back accepts SHALL be allowed.
REQ-015 cfg_ready SHALL be 0 while rst_n=0, become 1 on the first edge after release, and remain 1 thereafter.
REQ-016 On the accept edge, the target channel SHALL load its inc and en registers, clear its accumulator to 0, clear clken, clkout and its settle counter, and enter its lock FSM entry state.
REQ-017 A request with cfg_ch >= NCH SHALL be accepted and SHALL have no effect.
REQ-018 On each edge, an enabled channel that is not being configured SHALL compute {carry, acc} <= acc + inc, with the sum wrapping modulo 2^ACC_W.
REQ-019 clken[i] SHALL be registered from carry, giving one high cycle per overflow with latency 1 edge; clken[i] SHALL never be high for two consecutive cycles unless inc >= 2^(ACC_W-1).
REQ-020 A disabled channel SHALL hold acc=0, keep clken=0, and keep clkout=0.
REQ-021 The first accumulation after an accept SHALL occur on the edge following the accept edge.
REQ-022 Each channel SHALL have a lock FSM with states UNLOCKED, SETTLING and LOCKED, and lock[i]=1 only in LOCKED.
REQ-023 On an accept with en=1 and inc!=0 the FSM SHALL go to SETTLING; otherwise it SHALL go to UNLOCKED.
REQ-024 In SETTLING, each carry SHALL increment the settle counter; the carry that makes the counter equal SETTLE SHALL move the FSM to LOCKED on the same edge, so lock rises together with the SETTLE-th clken pulse.
REQ-025 LOCKED SHALL be left only by reset or by an accept to that channel.
REQ-026 A reconfiguration of a channel mid-SETTLING or while LOCKED SHALL restart settling from 0.
REQ-027 Reconfiguring one channel SHALL NOT disturb the accumulator, clken, clkout or lock of any other channel.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force all accumulators, inc, en and settle counters to 0, all FSMs to UNLOCKED, and clken=0, clkout=0, lock=0 and cfg_ready=0.
REQ-029 An assertion of rst_n mid-operation SHALL abort all channels.
REQ-030 After rst_n is released, no channel SHALL run until it is configured.

Verification
REQ-031 The bench SHALL cover this scenario: ACC_W=24, ch0 given inc=0x800000, en=1 -> clken[0] high every 2nd cycle, clkout[0] toggles each cycle, and lock[0] rises with the 16th pulse.
REQ-032 The bench SHALL cover this scenario: ch1 given inc=0x400000 -> clken[1] has period 4, the first pulse is 4 cycles after the accept edge, and clkout[1] shows a 2-high/2-low pattern.
REQ-033 The bench SHALL cover this scenario: ch0 reconfigured to inc=0x200000 after 10 pulses while SETTLING -> lock[0] stays 0, rises with the 16th pulse of the new rate, and ch1 is unaffected.
REQ-034 The bench SHALL cover this scenario: an accept with en=0, and separately an accept with inc=0 -> clken=0, clkout=0 and lock=0 indefinitely.
REQ-035 The bench SHALL cover this scenario: rst_n pulled low mid-run between clock edges -> all outputs are 0 before the next edge, and cfg_ready returns to 1 on the first edge after release.
REQ-036 The bench SHALL cover this scenario: cfg_ch=5 with NCH=2 -> the request is accepted and no output changes.

Source files
------------

// File: rtl/clken_synth.sv
// rtl/clken_synth.sv - multi-channel phase-accumulator clock-enable synthesizer with per-channel lock
//
// Purpose:
//   Each channel runs an ACC_W-bit phase accumulator. The carry out of the
//   accumulator becomes a one-cycle clock-enable pulse. The accumulator MSB
//   becomes a square wave. After SETTLE pulses following a configuration,
//   the lock output for that channel asserts.
//
// Ports:
//   clkin      - single clock, all logic on its rising edge
//   rst_n      - asynchronous active-low reset
//   cfg_valid  - configuration request present
//   cfg_ready  - block can accept a configuration request (1 after reset release)
//   cfg_ch     - target channel index (indices >= NCH are accepted and ignored)
//   cfg_inc    - phase increment, f_out = f_clkin * cfg_inc / 2^ACC_W
//   cfg_en     - enable for the target channel
//   clken      - per-channel one-cycle enable pulse (registered carry)
//   clkout     - per-channel square wave (accumulator MSB)
//   lock       - per-channel settled-and-running flag
module clken_synth #(
  parameter int NCH    = 2,
  parameter int ACC_W  = 24,
  parameter int SETTLE = 16
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_en,
  output logic [NCH-1:0]   clken,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   lock
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_SETTLING = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  logic accept;

  // Ready is purely a reset-release indicator: the block never back-pressures.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
    end
  end

  assign accept = cfg_valid & cfg_ready;

  for (genvar gi = 0; gi < NCH; gi++) begin : ch_g
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic             en_q;
    logic             clken_q;
    logic [7:0]       cnt_q;
    logic [1:0]       st_q;
    logic [ACC_W:0]   sum;
    logic             hit;

    // A request addressed past the last channel never matches any hit,
    // so it is consumed without side effects.
    assign hit = accept && (cfg_ch == 3'(gi));
    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
        acc_q   <= '0;
        inc_q   <= '0;
        en_q    <= 1'b0;
        clken_q <= 1'b0;
        cnt_q   <= '0;
        st_q    <= ST_UNLOCKED;
      end else if (hit) begin
        // Configuration takes priority over accumulation on the same edge;
        // the first accumulation with the new increment happens next edge.
        inc_q   <= cfg_inc;
        en_q    <= cfg_en;
        acc_q   <= '0;
        clken_q <= 1'b0;
        cnt_q   <= '0;
        st_q    <= (cfg_en && (cfg_inc != '0)) ? ST_SETTLING : ST_UNLOCKED;
      end else if (en_q) begin
        acc_q   <= sum[ACC_W-1:0];
        clken_q <= sum[ACC_W];
        // Lock is decided on the carry edge itself so that lock rises in
        // the same cycle as the SETTLE-th clken pulse.
        if ((st_q == ST_SETTLING) && sum[ACC_W]) begin
          cnt_q <= cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == SETTLE_CNT) begin
            st_q <= ST_LOCKED;
          end
        end
      end else begin
        acc_q   <= '0;
        clken_q <= 1'b0;
      end
    end

    assign clken[gi]  = clken_q;
    assign clkout[gi] = acc_q[ACC_W-1];
    assign lock[gi]   = (st_q == ST_LOCKED);
  end

endmodule
